// File: rtl/symbol_demapper.sv
// symbol_demapper: hard-decision 802.11a Gray demapper serialising NBPSC bits per I/Q sample, b0 first
module symbol_demapper #(
  parameter int W     = 16,
  parameter int A_LVL = 1024
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic [3:0]   rate,
  input  logic [W-1:0] i_in,
  input  logic [W-1:0] q_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         data_out,
  output logic         out_valid,
  output logic         rate_err
);
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [W:0] T2 = (W+1)'(2*A_LVL);
  localparam logic [W:0] T4 = (W+1)'(4*A_LVL);
  localparam logic [W:0] T6 = (W+1)'(6*A_LVL);
  state_t     state;
  logic [5:0] sh;
  logic [5:0] sym;
  logic [2:0] bits_left;
  logic [2:0] nb;
  logic [W:0] mi;
  logic [W:0] mq;
  logic       ip;
  logic       qp;
  logic       acc;
  // W+1-bit magnitudes keep |-2^(W-1)| representable
  assign mi = i_in[W-1] ? -{i_in[W-1], i_in} : {1'b0, i_in};
  assign mq = q_in[W-1] ? -{q_in[W-1], q_in} : {1'b0, q_in};
  assign ip = ~i_in[W-1];
  assign qp = ~q_in[W-1];
  assign nb = (rate == 4'b1101 || rate == 4'b1111) ? 3'd1 :
              (rate == 4'b0101 || rate == 4'b0111) ? 3'd2 :
              (rate == 4'b1001 || rate == 4'b1011) ? 3'd4 :
              (rate == 4'b0001 || rate == 4'b0011) ? 3'd6 : 3'd0;
  assign in_ready  = (state == IDLE) || (state == SHIFT && bits_left == 3'd1);
  assign acc       = in_valid && in_ready;
  assign data_out  = sh[5];
  assign out_valid = (state == SHIFT);
  always_comb begin
    sym = nb == 3'd1 ? {ip, 5'b0} :
          nb == 3'd2 ? {ip, qp, 4'b0} :
          nb == 3'd4 ? {ip, (mi < T2), qp, (mq < T2), 2'b0} :
                       {ip, (mi < T4), (mi >= T2 && mi < T6), qp, (mq < T4), (mq >= T2 && mq < T6)};
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      state     <= IDLE;
      sh        <= '0;
      bits_left <= '0;
      rate_err  <= 1'b0;
    end else begin
      rate_err <= acc && nb == 3'd0;
      if (acc && nb != 3'd0) begin
        sh        <= sym;
        bits_left <= nb;
        state     <= SHIFT;
      end else if (state == SHIFT) begin
        sh        <= {sh[4:0], 1'b0};
        bits_left <= bits_left - 3'd1;
        state     <= bits_left == 3'd1 ? IDLE : SHIFT;
      end
    end
  end
endmodule

// File: tb/tb_symbol_demapper.sv
// tb_symbol_demapper: directed and randomized checks of symbol_demapper against a bit-queue reference model
module tb_symbol_demapper;
  localparam int W = 16;
  localparam int A = 1024;
  logic         Clk = 0;
  logic         reset = 1;
  logic [3:0]   rate = 0;
  logic [W-1:0] i_in = 0;
  logic [W-1:0] q_in = 0;
  logic         in_valid = 0;
  logic         in_ready, data_out, out_valid, rate_err;
  int checks = 0;
  int passed = 0;
  bit exp_q[$];
  bit got_q[$];
  bit mready = 1;
  bit err_exp = 0;
  bit armed = 0;
  always #5 Clk = ~Clk;
  symbol_demapper #(.W(W), .A_LVL(A)) dut (
    .Clk(Clk), .reset(reset), .rate(rate), .i_in(i_in), .q_in(q_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid), .rate_err(rate_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int nbpsc(input logic [3:0] r);
    case (r)
      4'b1101, 4'b1111: return 1;
      4'b0101, 4'b0111: return 2;
      4'b1001, 4'b1011: return 4;
      4'b0001, 4'b0011: return 6;
      default: return 0;
    endcase
  endfunction
  task automatic push_sym(input int i, input int q, input int n);
    int mi = i < 0 ? -i : i;
    int mq = q < 0 ? -q : q;
    if (n == 1) exp_q.push_back(i >= 0);
    else if (n == 2) begin
      exp_q.push_back(i >= 0); exp_q.push_back(q >= 0);
    end else if (n == 4) begin
      exp_q.push_back(i >= 0); exp_q.push_back(mi < 2*A);
      exp_q.push_back(q >= 0); exp_q.push_back(mq < 2*A);
    end else begin
      exp_q.push_back(i >= 0); exp_q.push_back(mi < 4*A); exp_q.push_back(mi >= 2*A && mi < 6*A);
      exp_q.push_back(q >= 0); exp_q.push_back(mq < 4*A); exp_q.push_back(mq >= 2*A && mq < 6*A);
    end
  endtask
  always @(posedge Clk) begin
    int n;
    err_exp = 0;
    if (reset) begin
      exp_q.delete();
      mready = 1;
    end else if (in_valid && mready) begin
      n = nbpsc(rate);
      if (n == 0) err_exp = 1;
      else push_sym($signed(i_in), $signed(q_in), n);
    end
    armed = 1;
  end
  always @(negedge Clk) begin
    bit b;
    if (armed) begin
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("data_out", data_out, b);
      end else chk("data_out_idle", data_out, 0);
      if (out_valid) got_q.push_back(data_out);
      mready = exp_q.size() == 0;
      chk("in_ready", in_ready, mready);
      chk("rate_err", rate_err, err_exp);
    end
  end
  function automatic logic [31:0] pack();
    logic [31:0] v = 0;
    foreach (got_q[k]) v = {v[30:0], got_q[k]};
    return v;
  endfunction
  task automatic send(input logic [3:0] r, input int i, input int q);
    int k = 0;
    @(negedge Clk); #1;
    while (!mready && k < 64) begin
      @(negedge Clk); #1;
      k++;
    end
    if (!mready) chk("ready_timeout", 0, 1);
    rate = r; i_in = i[W-1:0]; q_in = q[W-1:0]; in_valid = 1;
    @(posedge Clk); #1;
    in_valid = 0; rate = 4'($urandom); i_in = 16'($urandom); q_in = 16'($urandom);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask
  function automatic int pick();
    int s = $urandom_range(0, 2);
    if (s == 0) return $signed(16'($urandom));
    if (s == 1) return ($urandom_range(0, 16) - 8) * A + $urandom_range(0, 2) - 1;
    return $urandom_range(0, 1) ? -32768 : 32767;
  endfunction
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [3:0] codes [0:11];
    codes = '{4'b1101, 4'b1111, 4'b0101, 4'b0111, 4'b1001, 4'b1011,
              4'b0001, 4'b0011, 4'b0000, 4'b1110, 4'b0110, 4'b1000};
    repeat (3) @(posedge Clk);
    #1 reset = 0;
    @(negedge Clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    idle(1);
    got_q.delete();
    send(4'b0001, -3*A, 5*A);
    idle(2);
    reset = 1;
    @(posedge Clk); #1 reset = 0;
    @(negedge Clk);
    chk("T1_out_valid", out_valid, 0);
    chk("T1_data_out", data_out, 0);
    chk("T1_in_ready", in_ready, 1);
    idle(8);
    chk("T1_bits", got_q.size(), 2);
    got_q.delete();
    send(4'b1101, -5, 0);
    send(4'b1101, 0, 0);
    idle(4);
    chk("T2_count", got_q.size(), 2);
    chk("T2_bits", pack(), 2'b01);
    got_q.delete();
    send(4'b1001, 3*A, -A);
    send(4'b1001, 2*A, -2*A);
    idle(8);
    chk("T3_count", got_q.size(), 8);
    chk("T3_bits", pack(), 8'b1001_1000);
    got_q.delete();
    send(4'b0001, -3*A, 5*A);
    send(4'b0001, 7*A, -7*A);
    idle(8);
    chk("T4_count", got_q.size(), 12);
    chk("T4_bits", pack(), 12'b011101_100000);
    got_q.delete();
    send(4'b0000, 123, -456);
    @(negedge Clk);
    chk("T5_pulse", rate_err, 1);
    chk("T5_ready", in_ready, 1);
    @(negedge Clk);
    chk("T5_pulse_end", rate_err, 0);
    idle(2);
    chk("T5_no_bits", got_q.size(), 0);
    send(4'b0001, 4*A, -6*A);
    idle(5);
    send(4'b0000, 1, 1);
    idle(8);
    got_q.delete();
    for (int s = 0; s < 48; s++) begin
      repeat ($urandom_range(0, 3)) idle(1);
      send($urandom_range(0, 1) ? 4'b0101 : 4'b0111, pick(), pick());
    end
    idle(8);
    chk("T6_count", got_q.size(), 96);
    got_q.delete();
    send(4'b1001, -32768, 0);
    idle(8);
    chk("T7_bits", pack(), 4'b0011);
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(codes[$urandom_range(0, 11)], pick(), pick());
    end
    idle(10);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
